hit_or_miss_ctrl: RTL

HIT_OR_MISS_CTRL -- requirements
Module: hit_or_miss_ctrl

---
 rtl/hit_or_miss_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hit_or_miss_ctrl.sv
// Reaction game controller: lights one random target LED per round and
// scores a hit or a miss depending on the first rising button edge.
module hit_or_miss_ctrl #(
    parameter logic [23:0] WINDOW = 24'd12_500_000,
    parameter logic [23:0] GAP    = 24'd6_250_000,
    parameter logic [7:0]  ROUNDS = 8'd20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] rnd,
    input  logic [7:0]  btn,
    output logic [7:0]  LED,
    output logic [7:0]  hits,
    output logic [7:0]  misses,
    output logic        round_done,
    output logic        busy,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GAP    = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  r_state;
    logic [23:0] r_gap_cnt;
    logic [23:0] r_win_cnt;
    logic [7:0]  r_round;
    logic [2:0]  r_tgt;
    logic        r_tgt_vld;
    logic [7:0]  r_btn_prev;
    logic [7:0]  r_led;
    logic [7:0]  r_hits;
    logic [7:0]  r_misses;
    logic        r_round_done;
    logic        r_busy;
    logic        r_game_over;

    logic [7:0]  w_edges;
    logic [2:0]  w_arm_idx;
    logic        w_hit;
    logic        w_unused_rnd;

    assign w_edges      = btn & ~r_btn_prev;
    // Avoid repeating the previous target; wraps 7 -> 0.
    assign w_arm_idx    = (r_tgt_vld && (rnd[2:0] == r_tgt)) ? rnd[2:0] + 3'd1 : rnd[2:0];
    assign w_hit        = (w_edges == (8'd1 << r_tgt));
    assign w_unused_rnd = ^rnd[12:3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= 24'd0;
            r_win_cnt    <= 24'd0;
            r_round      <= 8'd0;
            r_tgt        <= 3'd0;
            r_tgt_vld    <= 1'b0;
            r_btn_prev   <= 8'd0;
            r_led        <= 8'd0;
            r_hits       <= 8'd0;
            r_misses     <= 8'd0;
            r_round_done <= 1'b0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_btn_prev   <= btn;
            r_round_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_GAP;
                        r_gap_cnt   <= 24'd0;
                        r_round     <= 8'd0;
                        r_hits      <= 8'd0;
                        r_misses    <= 8'd0;
                        r_tgt_vld   <= 1'b0;
                        r_led       <= 8'd0;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP - 24'd1) begin
                        r_state   <= S_ARM;
                        r_gap_cnt <= 24'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 24'd1;
                    end
                end
                S_ARM: begin
                    r_tgt     <= w_arm_idx;
                    r_tgt_vld <= 1'b1;
                    r_led     <= 8'd1 << w_arm_idx;
                    r_win_cnt <= 24'd0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A press on the last window cycle wins over the timeout.
                    if ((w_edges != 8'd0) || (r_win_cnt == WINDOW - 24'd1)) begin
                        r_state      <= S_RESULT;
                        r_led        <= 8'd0;
                        r_round_done <= 1'b1;
                        r_round      <= r_round + 8'd1;
                        if ((w_edges != 8'd0) && w_hit) begin
                            if (r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
                        end else begin
                            if (r_misses != 8'hFF) r_misses <= r_misses + 8'd1;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + 24'd1;
                    end
                end
                S_RESULT: begin
                    if (r_round == ROUNDS) begin
                        r_state     <= S_DONE;
                        r_led       <= 8'hFF;
                        r_busy      <= 1'b0;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= 24'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign LED        = r_led;
    assign hits       = r_hits;
    assign misses     = r_misses;
    assign round_done = r_round_done;
    assign busy       = r_busy;
    assign game_over  = r_game_over;

endmodule
